seq_divider_16_bit: RTL
=======================

// Module: seq_divider_16_bit
// PURPOSE
//   Multi-cycle unsigned divider, the inverse-operation partner to the carry-lookahead adder datapath.
//   Restoring shift-subtract algorithm: one 17-bit trial subtract (a - b via ~b + 1) per clock, WIDTH iterations.
//   Sits beside the ALU and is driven by the ALU control through a start/busy/done handshake.
//   Results are held stable until the next accepted operation.
// PARAMETERS
//   WIDTH   16   operand/result width in bits (>= 2)
// PORTS
//   clk           in   1      rising-edge clock
//   reset         in   1      synchronous, active-high reset
//   start         in   1      request; sampled only when IDLE or DONE
//   dividend      in   WIDTH  numerator, captured on the accepting edge
//   divisor       in   WIDTH  denominator, captured on the accepting edge
//   busy          out  1      high while state == RUN
//   done          out  1      high for exactly one cycle (state == DONE); results valid
//   quotient      out  WIDTH  registered quotient
//   remainder     out  WIDTH  registered remainder
//   div_by_zero   out  1      registered; set for an operation whose divisor was 0
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal regs cleared.
//   Reset wins over every other event, including mid-RUN: the operation is abandoned, no done pulse.
//   States: IDLE, RUN, DONE.
//   IDLE: start=1 & divisor!=0 -> capture dividend into shift reg Q, divisor into D, partial rem R=0,
//     iteration counter=0; next state RUN. start=1 & divisor==0 -> next state DONE directly.
//   RUN (one iteration per edge): T = {R[WIDTH-1:0], Q[WIDTH-1]} - {1'b0, D} (WIDTH+1 bits);
//     if T[WIDTH]==0 (no borrow): R<=T[WIDTH-1:0], Q<={Q[WIDTH-2:0],1}; else R<={R[WIDTH-2:0],Q[WIDTH-1]},
//     Q<={Q[WIDTH-2:0],0}. Counter increments; on iteration WIDTH (counter==WIDTH-1) next state DONE,
//     and quotient/remainder outputs load the final Q/R values on that same edge.
//   DONE: done=1 for one cycle. start=1 here is accepted exactly as in IDLE (back-to-back ops);
//     otherwise next state IDLE.
//   Latency: start accepted at edge E0 -> done high in the cycle after edge E0+WIDTH (16 for default).
//   Divide by zero: done high in the cycle after E0; quotient={WIDTH{1'b1}}, remainder=dividend,
//     div_by_zero=1. Any non-zero-divisor op clears div_by_zero when it loads results.
//   start while RUN is ignored (no effect, no queueing); operand inputs are don't-care except on accept edge.
//   quotient/remainder/div_by_zero change only on the edge entering DONE; stable in IDLE and RUN.
//   Invariant on every done: dividend == quotient*divisor + remainder, remainder < divisor (divisor != 0).
// TESTING
//   reset held 2 cycles, then released -> all outputs 0, busy=0, done=0, state IDLE.
//   start, 100/7 -> busy for 16 cycles, done 1 cycle after edge E0+16; quotient=14, remainder=2.
//   start, 16'hFFFF/16'h0001 -> quotient=16'hFFFF, remainder=0; 16'h0005/16'h0009 -> quotient=0, remainder=5.
//   start, 1234/0 -> done in cycle after E0, quotient=16'hFFFF, remainder=1234, div_by_zero=1;
//     next op 9/3 -> quotient=3, remainder=0, div_by_zero=0.
//   start pulsed again mid-RUN with other operands -> ignored, original result delivered; start held
//     during done cycle -> second op accepted, done again 16 cycles later.
//   reset asserted at iteration 8 -> no done pulse, outputs 0; then random 1000 ops checked against invariant.

Source files
------------

// File: rtl/seq_divider_16_bit.sv
// Multi-cycle unsigned restoring divider.
// One trial subtract per clock, WIDTH iterations per operation. Divide by zero
// completes in a single cycle with quotient all-ones and remainder = dividend.
//
// Handshake: start is sampled only while the divider is idle or on its done
// cycle. Operands are captured on that accepting edge. busy is high for the
// WIDTH iteration cycles. done is high for exactly one cycle, and the results
// are valid from that cycle until the next operation completes. A start that
// arrives while busy is dropped.
module seq_divider_16_bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] q_reg;   // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] d_reg;   // captured divisor
  logic [WIDTH-1:0] r_reg;   // partial remainder
  logic [CW-1:0]    count;   // iteration index, 0 .. WIDTH-1
  logic [WIDTH:0]   trial;   // {R, next dividend bit} - D, top bit = borrow
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;

  // Trial subtract via two's complement (~D + 1); restore the shifted remainder on borrow
  always_comb begin
    trial  = {r_reg, q_reg[WIDTH-1]} + {1'b1, ~d_reg} + {{WIDTH{1'b0}}, 1'b1};
    q_next = '0;
    r_next = '0;
    if (!trial[WIDTH]) begin
      r_next = trial[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b1};
    end else begin
      r_next = {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
      q_next = {q_reg[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          // DONE behaves like IDLE for start, so operations can run back to back
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            if (divisor == '0) begin
              state       <= S_DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              q_reg <= dividend;
              d_reg <= divisor;
              r_reg <= '0;
              count <= '0;
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            // Final iteration: results load on the same edge that enters DONE
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
